bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised memory-mapped interconnect between the picorv32 native memory port and up to NUM_SLAVES peripherals. It replaces hand-written select and read-data muxing with a table-driven address decoder. It registers each transaction, terminates unmapped or hung accesses with an error response, and raises an error interrupt. It sits between the CPU and all slaves (ROM, flash, SRAM, timer, UART, SPI, GPIO).

## Interface
- NUM_SLAVES, 8: number of slave ports, 1..16.
- SLAVE_BASE, {NUM_SLAVES{32'h0}}: packed base addresses, slave i at bits [32*i+31:32*i].
- SLAVE_MASK, {NUM_SLAVES{32'hFFFF_FFFF}}: packed match masks, same packing.
- TMO_WIDTH, 8: timeout counter width.
- TIMEOUT_CYCLES, 255: maximum cycles a slave may hold off ready; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error response.

Ports (clock and reset first):
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_valid  in  1  CPU request.
- m_addr  in  32  CPU byte address.
- m_wdata  in  32  CPU write data.
- m_wstrb  in  4  byte strobes; 0 means read.
- m_ready  out  1  one-cycle response strobe.
- m_rdata  out  32  response data, registered.
- s_select  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  32  registered address to all slaves.
- s_wdata  out  32  registered write data.
- s_wstrb  out  4  registered strobes.
- s_ready  in  NUM_SLAVES  per-slave ready.
- s_rdata  in  32*NUM_SLAVES  packed per-slave read data.
- err_clr  in  1  clears err_irq.
- err_irq  out  1  sticky error flag, level.
- err_addr  out  32  address of the most recent errored access.
- err_cause  out  2  01 = decode miss, 10 = timeout.

## Operation
- Hit rule: slave i hits when (m_addr & MASK[i]) == BASE[i]. If several slaves hit, the lowest index wins.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - If m_valid is high and the address hits, register the one-hot select, s_addr, s_wdata and s_wstrb, clear the timeout counter, and go to ACTIVE.
  - If m_valid is high and nothing hits, load m_rdata=ERR_DATA, capture err_addr, set err_cause=01, set err_irq, and go to RESP.
- ACTIVE:
  - s_select drives the registered one-hot.
  - On s_ready[sel], capture s_rdata[sel] into m_rdata and go to RESP.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ready, load ERR_DATA, capture err_addr, set err_cause=10, set err_irq, and go to RESP.
  - s_ready from unselected slaves is ignored.
- RESP: m_ready=1 for exactly one cycle, s_select=0, then go to IDLE.
- Writes return m_rdata from the slave's data_o. The value is don't-care to the CPU but still registered.
- err_irq: if an error event and err_clr occur in the same cycle, the set wins. err_addr and err_cause are overwritten by each new error.

## Timing
- Reset values: state IDLE, m_ready=0, m_rdata=0, s_select=0, s_addr=0, s_wdata=0, s_wstrb=0, err_irq=0, err_addr=0, err_cause=00, counter=0.
- Minimum latency: m_valid sampled at edge N gives s_select high from N+1. If s_ready is high at N+1, m_ready is high in cycle N+2.
- Decode miss: m_ready in the cycle after m_valid is sampled.
- Timeout: s_select is high for exactly TIMEOUT_CYCLES cycles, followed by one RESP cycle.
- s_ready asserted in the same cycle the timeout expires: ready wins, and no error is recorded.
- m_valid dropped while ACTIVE (protocol violation): return to IDLE next cycle, s_select=0, no m_ready, no error.
- Back-to-back requests: m_valid high in the cycle after RESP is accepted from IDLE normally. Throughput is at most one transaction per 3 cycles.
- Reset asserted mid-transaction: all outputs take their reset values immediately (asynchronously). Pending slave accesses are abandoned.
- TIMEOUT_CYCLES=0: the ACTIVE state waits indefinitely.

## Structure
- Package bus_fabric_pkg holds:
  - state encoding (IDLE, ACTIVE, RESP);
  - err_cause codes ERR_NONE, ERR_DECODE, ERR_TIMEOUT;
  - the default ERR_DATA;
  - the standard SoC map constants (ROM, FLASH, SRAM, LED, SYSTICK, UART, SPI, GPIO base/mask pairs) used to build SLAVE_BASE and SLAVE_MASK at the top level.
- Sub-module bus_addr_decode is combinational. It is parametrised by NUM_SLAVES, SLAVE_BASE and SLAVE_MASK, and outputs a priority-resolved one-hot hit vector plus a hit flag.
- bus_fabric holds the FSM, the request registers, the timeout counter, the read-data mux and the error registers.

## Test plan
- Read slave 2 (BASE 32'h8000_0100, MASK 32'hFFFF_FFF0) at addr 32'h8000_0104, s_ready[2] in the first ACTIVE cycle, s_rdata = 32'h1234_5678 -> s_select=8'b0000_0100 for 1 cycle; m_ready in cycle N+2 with m_rdata=32'h1234_5678; err_irq=0.
- Write 32'hA5 with wstrb=4'b0001 to overlapping slaves 0 and 3 -> s_select=8'b0000_0001; s_wdata=32'hA5, s_wstrb=4'b0001.
- Read 32'h4000_0000 (unmapped) -> m_ready at N+1 with m_rdata=32'hDEAD_BEEF; err_irq=1, err_cause=01, err_addr=32'h4000_0000. A subsequent err_clr pulse clears err_irq.
- Slave never readies, TIMEOUT_CYCLES=4 -> s_select high for exactly 4 cycles; m_ready on the 5th with ERR_DATA; err_cause=10. Repeat with s_ready on the 4th cycle -> normal data, no error.
- Assert reset in ACTIVE -> s_select and m_ready go to 0 immediately. After release, a new read completes normally.
- err_clr asserted in the same cycle as a decode miss -> err_irq remains 1.

Source files
------------

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus fabric:
// FSM states, error cause codes and the standard SoC address map.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Standard SoC map, one base/mask pair per peripheral
    localparam logic [31:0] ROM_BASE     = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK     = 32'hFFFF_F000;
    localparam logic [31:0] FLASH_BASE   = 32'h0010_0000;
    localparam logic [31:0] FLASH_MASK   = 32'hFFF0_0000;
    localparam logic [31:0] SRAM_BASE    = 32'h0002_0000;
    localparam logic [31:0] SRAM_MASK    = 32'hFFFE_0000;
    localparam logic [31:0] LED_BASE     = 32'h0300_0000;
    localparam logic [31:0] LED_MASK     = 32'hFFFF_FF00;
    localparam logic [31:0] SYSTICK_BASE = 32'h0300_0100;
    localparam logic [31:0] SYSTICK_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] UART_BASE    = 32'h0200_0000;
    localparam logic [31:0] UART_MASK    = 32'hFFFF_FFF0;
    localparam logic [31:0] SPI_BASE     = 32'h0200_0010;
    localparam logic [31:0] SPI_MASK     = 32'hFFFF_FFF0;
    localparam logic [31:0] GPIO_BASE    = 32'h0300_0200;
    localparam logic [31:0] GPIO_MASK    = 32'hFFFF_FF00;

    localparam int SOC_NUM_SLAVES = 8;

    // Slave 0 occupies the least significant word
    localparam logic [32*SOC_NUM_SLAVES-1:0] SOC_SLAVE_BASE = {
        GPIO_BASE, SPI_BASE, UART_BASE, SYSTICK_BASE,
        LED_BASE, SRAM_BASE, FLASH_BASE, ROM_BASE
    };
    localparam logic [32*SOC_NUM_SLAVES-1:0] SOC_SLAVE_MASK = {
        GPIO_MASK, SPI_MASK, UART_MASK, SYSTICK_MASK,
        LED_MASK, SRAM_MASK, FLASH_MASK, ROM_MASK
    };

endpackage

// File: rtl/bus_addr_decode.sv
// Table-driven address decoder: per-slave base/mask match, resolved so the
// lowest-index matching slave wins, plus an any-hit flag.
module bus_addr_decode
    import bus_fabric_pkg::*;
#(
    parameter int                      NUM_SLAVES = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FFFF}}
) (
    input  logic [31:0]           i_addr,
    output logic [NUM_SLAVES-1:0] o_hit_onehot,
    output logic                  o_hit
);

    logic [NUM_SLAVES-1:0] w_raw_hit;

    // raw match of every slave window against the address
    always_comb begin
        w_raw_hit = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_raw_hit[i] = ((i_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
        end
    end

    // priority resolution: a slave is selected only if no lower index matched
    always_comb begin
        logic w_found;
        w_found      = 1'b0;
        o_hit_onehot = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            o_hit_onehot[i] = w_raw_hit[i] & ~w_found;
            w_found         = w_found | w_raw_hit[i];
        end
        o_hit = w_found;
    end

endmodule

// File: rtl/bus_fabric.sv
// Registered interconnect between the picorv32 native memory port and up to
// NUM_SLAVES peripherals, with decode-miss and timeout error termination.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
    parameter int                       TMO_WIDTH      = 8,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_select,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic                     err_clr,
    output logic                     err_irq,
    output logic [31:0]              err_addr,
    output logic [1:0]               err_cause
);

    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);

    state_e                r_state;
    logic [NUM_SLAVES-1:0] r_sel;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_m_ready;
    logic [31:0]           r_m_rdata;
    logic                  r_err_irq;
    logic [31:0]           r_err_addr;
    logic [1:0]            r_err_cause;
    logic [TMO_WIDTH-1:0]  r_tmo_cnt;

    logic [NUM_SLAVES-1:0] w_hit_onehot;
    logic                  w_hit;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;
    logic                  w_tmo_expired;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_addr       (m_addr),
        .o_hit_onehot (w_hit_onehot),
        .o_hit        (w_hit)
    );

    // ready and read data of the selected slave only; others are masked off
    always_comb begin
        w_sel_rdata = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_rdata = w_sel_rdata | (s_rdata[32*i +: 32] & {32{r_sel[i]}});
        end
        w_sel_ready = |(s_ready & r_sel);
    end

    // last permitted ACTIVE cycle; never reached when the timeout is disabled
    always_comb begin
        w_tmo_expired = TMO_EN && (r_tmo_cnt == TMO_LAST);
    end

    // transaction FSM with request, response and error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= {NUM_SLAVES{1'b0}};
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'b0000;
            r_m_ready   <= 1'b0;
            r_m_rdata   <= 32'h0000_0000;
            r_err_irq   <= 1'b0;
            r_err_addr  <= 32'h0000_0000;
            r_err_cause <= ERR_NONE;
            r_tmo_cnt   <= {TMO_WIDTH{1'b0}};
        end else begin
            r_m_ready <= 1'b0;
            // a clear is overridden below by any error raised this cycle
            if (err_clr) begin
                r_err_irq <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (w_hit) begin
                            r_sel     <= w_hit_onehot;
                            r_addr    <= m_addr;
                            r_wdata   <= m_wdata;
                            r_wstrb   <= m_wstrb;
                            r_tmo_cnt <= {TMO_WIDTH{1'b0}};
                            r_state   <= ST_ACTIVE;
                        end else begin
                            r_m_rdata   <= ERR_DATA;
                            r_err_addr  <= m_addr;
                            r_err_cause <= ERR_DECODE;
                            r_err_irq   <= 1'b1;
                            r_m_ready   <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!m_valid) begin
                        r_sel   <= {NUM_SLAVES{1'b0}};
                        r_state <= ST_IDLE;
                    end else if (w_sel_ready) begin
                        r_m_rdata <= w_sel_rdata;
                        r_m_ready <= 1'b1;
                        r_sel     <= {NUM_SLAVES{1'b0}};
                        r_state   <= ST_RESP;
                    end else if (w_tmo_expired) begin
                        r_m_rdata   <= ERR_DATA;
                        r_err_addr  <= r_addr;
                        r_err_cause <= ERR_TIMEOUT;
                        r_err_irq   <= 1'b1;
                        r_m_ready   <= 1'b1;
                        r_sel       <= {NUM_SLAVES{1'b0}};
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= {NUM_SLAVES{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready   = r_m_ready;
    assign m_rdata   = r_m_rdata;
    assign s_select  = r_sel;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign s_wstrb   = r_wstrb;
    assign err_irq   = r_err_irq;
    assign err_addr  = r_err_addr;
    assign err_cause = r_err_cause;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: stimulus pushes expected responses, a
// monitor pops and compares them whenever m_ready is presented.
module tb_bus_fabric;

    localparam logic [255:0] TB_BASE = {
        32'h9000_0000, 32'h7000_0000, 32'h6000_0000, 32'h3000_0000,
        32'h1000_0000, 32'h8000_0100, 32'h2000_0000, 32'h1000_0000
    };
    localparam logic [255:0] TB_MASK = {
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hFF00_0000, 32'hFFFF_FFF0, 32'hF000_0000, 32'hF000_0000
    };

    typedef struct packed {
        logic [31:0] rdata;
        logic        irq;
        logic [1:0]  cause;
        logic [31:0] eaddr;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [7:0]   s_select;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [7:0]   s_ready;
    logic [255:0] s_rdata;
    logic         err_clr;
    logic         err_irq;
    logic [31:0]  err_addr;
    logic [1:0]   err_cause;

    int   total;
    int   bad;
    exp_t q[$];
    logic        exp_irq;
    logic [1:0]  exp_cause;
    logic [31:0] exp_eaddr;

    bus_fabric #(
        .NUM_SLAVES     (8),
        .SLAVE_BASE     (TB_BASE),
        .SLAVE_MASK     (TB_MASK),
        .TMO_WIDTH      (8),
        .TIMEOUT_CYCLES (4),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_select  (s_select),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_clr   (err_clr),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_cause (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [7:0] sel);
        logic [31:0] d;
        d = 32'h0000_0000;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) d = (i == 2) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
        end
        return d;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && m_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata %h expected no response", m_rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_rdata", m_rdata, e.rdata);
                chk("resp_err_irq", 32'(err_irq), 32'(e.irq));
                chk("resp_err_cause", 32'(err_cause), 32'(e.cause));
                chk("resp_err_addr", err_addr, e.eaddr);
            end
        end
    end

    // rdy_at: ACTIVE cycle index at which the slave readies, -1 = never
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [7:0] exp_sel, input int rdy_at, input bit clr_now);
        exp_t e;
        int   cyc;
        int   exp_cycles;
        bit   done;
        bit   is_err;
        is_err = (exp_sel == 8'h00) || (rdy_at < 0);
        exp_cycles = (exp_sel == 8'h00) ? 0 : ((rdy_at < 0) ? 4 : rdy_at + 1);
        if (clr_now) exp_irq = 1'b0;
        if (is_err) begin
            exp_irq   = 1'b1;
            exp_cause = (exp_sel == 8'h00) ? 2'b01 : 2'b10;
            exp_eaddr = addr;
        end
        e.rdata = is_err ? 32'hDEAD_BEEF : slv_data(exp_sel);
        e.irq   = exp_irq;
        e.cause = exp_cause;
        e.eaddr = exp_eaddr;
        q.push_back(e);
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        err_clr = clr_now;
        s_ready = 8'h00;
        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (m_ready) begin
                done = 1'b1;
            end else begin
                chk("s_select", 32'(s_select), 32'(exp_sel));
                if (cyc == 0) begin
                    chk("s_addr", s_addr, addr);
                    chk("s_wdata", s_wdata, wdata);
                    chk("s_wstrb", 32'(s_wstrb), 32'(wstrb));
                end
                s_ready = (cyc == rdy_at) ? exp_sel : 8'h00;
                cyc++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_m_ready: got no response expected m_ready within 40 cycles");
        end
        chk("active_cycles", 32'(cyc), 32'(exp_cycles));
        chk("select_in_resp", 32'(s_select), 32'h0);
        m_valid = 1'b0;
        s_ready = 8'h00;
        @(negedge clk);
        chk("ready_one_cycle", 32'(m_ready), 32'h0);
    endtask

    task automatic clear_irq();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_irq = 1'b0;
        chk("irq_cleared", 32'(err_irq), 32'h0);
        chk("cause_kept", 32'(err_cause), 32'(exp_cause));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        exp_irq = 1'b0;
        exp_cause = 2'b00;
        exp_eaddr = 32'h0;
        reset = 1'b1;
        m_valid = 1'b0;
        m_addr = 32'h0;
        m_wdata = 32'h0;
        m_wstrb = 4'h0;
        s_ready = 8'h00;
        err_clr = 1'b0;
        for (int i = 0; i < 8; i++) s_rdata[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
        s_rdata[95:64] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_select", 32'(s_select), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_err_irq", 32'(err_irq), 32'h0);
        chk("rst_err_cause", 32'(err_cause), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        reset = 1'b0;

        xfer(32'h8000_0104, 32'h0, 4'b0000, 8'b0000_0100, 0, 1'b0);
        xfer(32'h1000_0010, 32'h0000_00A5, 4'b0001, 8'b0000_0001, 0, 1'b0);
        xfer(32'h4000_0000, 32'h0, 4'b0000, 8'b0000_0000, 0, 1'b0);
        clear_irq();
        xfer(32'h2000_0004, 32'h0, 4'b0000, 8'b0000_0010, -1, 1'b0);
        clear_irq();
        xfer(32'h2000_0008, 32'h0, 4'b0000, 8'b0000_0010, 3, 1'b0);

        // m_valid withdrawn while ACTIVE: abort silently
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h2000_000C;
        m_wstrb = 4'b0000;
        @(negedge clk);
        chk("abort_sel", 32'(s_select), 32'h02);
        m_valid = 1'b0;
        @(negedge clk);
        chk("abort_sel_clr", 32'(s_select), 32'h0);
        chk("abort_no_ready", 32'(m_ready), 32'h0);
        chk("abort_no_err", 32'(err_irq), 32'(exp_irq));

        // asynchronous reset in the middle of an ACTIVE access
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h3000_0008;
        @(negedge clk);
        chk("pre_rst_sel", 32'(s_select), 32'h10);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_sel", 32'(s_select), 32'h0);
        chk("async_rst_ready", 32'(m_ready), 32'h0);
        chk("async_rst_cause", 32'(err_cause), 32'h0);
        chk("async_rst_eaddr", err_addr, 32'h0);
        m_valid = 1'b0;
        exp_irq = 1'b0;
        exp_cause = 2'b00;
        exp_eaddr = 32'h0;
        @(negedge clk);
        reset = 1'b0;

        xfer(32'h8000_0108, 32'h0, 4'b0000, 8'b0000_0100, 0, 1'b0);
        xfer(32'h5000_0000, 32'h0, 4'b0000, 8'b0000_0000, 0, 1'b1);
        chk("set_beats_clr", 32'(err_irq), 32'h1);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
